event_encoder: RTL
==================

// Module: event_encoder
// PURPOSE
//   Sequential N-to-log2(N) encoder: the return path for the decoder blocks.
//   - Latches event requests on N one-hot-per-source lines into a sticky pending set.
//   - Encodes one pending source at a time into a binary index.
//   - Hands each index to a consumer over a valid/ready handshake.
//   - Clears each source's pending bit once its index has been taken.
//   Sits between scattered event sources (decoded selects, status lines) and a single index-consuming controller.
// PARAMETERS
//   N            8            number of request lines (N >= 2)
//   IDXW         $clog2(N)    width of encoded index
//   ROUND_ROBIN  0            0 = fixed priority (lowest index wins); 1 = rotating priority after last served
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   req_in       in   N      per-source event request, sampled every cycle
//   clr          in   1      synchronous flush of all pending events
//   out_valid    out  1      out_idx holds a valid encoded event
//   out_ready    in   1      consumer accepts out_idx when out_valid=1
//   out_idx      out  IDXW   encoded index of the event being offered
//   pending      out  N      registered pending set, for debug/status
//   any_pending  out  1      |pending, registered
//   overflow     out  1      one-cycle pulse: request hit an already-pending bit
// BEHAVIOUR
//   Reset (rst_n=0, async): pending=0, out_valid=0, out_idx=0, any_pending=0, overflow=0, state=IDLE, rr_ptr=N-1.
//   Definitions:
//     - fire   = out_valid & out_ready.
//     - served = one-hot(out_idx) if fire, else 0.
//   Pending update, every cycle unless clr:
//     - pending <= (pending & ~served) | req_in.
//     - If a bit is served and re-requested in the same cycle, the set wins; the bit stays pending as a new event, with no overflow.
//     - overflow <= |(req_in & pending & ~served).
//     - Duplicate requests merge; an event is never counted twice.
//   Encoder input:
//     - avail = pending & ~served.
//     - Fixed priority: lowest set index of avail.
//     - Round-robin: first set index of avail searching upward from rr_ptr+1, wrapping at N-1 to 0.
//   State machine:
//     - IDLE: out_valid=0. If avail != 0, load out_idx with the encoded index, set out_valid=1 and go to OFFER.
//     - OFFER, no fire: out_idx and out_valid are held stable, with no preemption by higher-priority arrivals.
//     - OFFER, fire with avail != 0: load the next index the same cycle and stay in OFFER (back-to-back, 1 index per cycle).
//     - OFFER, fire with avail == 0: out_valid <= 0 and go to IDLE.
//     - rr_ptr updates to out_idx on each fire.
//   Latency:
//     - req_in at cycle t reaches pending at t+1.
//     - From IDLE, out_valid=1 at t+2.
//   clr (sync, highest priority after reset):
//     - pending <= 0, out_valid <= 0, state <= IDLE, rr_ptr <= N-1, overflow <= 0.
//     - req_in in the same cycle is dropped.
//     - A fire coinciding with clr counts as accepted by the consumer.
//   Outputs:
//     - out_idx is don't-care-free: it holds its last value when out_valid=0.
//     - No combinational path from req_in or out_ready to any output.
//   Reset mid-offer: out_valid drops immediately (async); the offered event is lost.
// TESTING
//   1 Pulse req_in=8'h20 at cycle 0, out_ready=1 -> out_valid=1, out_idx=5 at cycle 2; pending=0 and out_valid=0 at cycle 3.
//   2 Pulse req_in=8'h85, fixed priority, out_ready=1 -> out_idx 0,2,7 on consecutive cycles, then out_valid=0.
//   3 Backpressure, part 1: pending={2}, out_ready=0 for 10 cycles, pulse req_in=8'h01 mid-stall -> out_idx stays 2 throughout.
//     Backpressure, part 2: release ready -> idx 2 then 0.
//   4 Overflow: req_in bit 3 at cycles 0 and 3, out_ready=0 -> overflow=1 at cycle 4 only.
//     Then raise ready -> exactly one idx 3 delivered.
//   5 ROUND_ROBIN=1, req_in=8'hFF held, out_ready=1 -> out_idx 0,1,...,7,0,1 with no overflow on a served bit.
//   6 Flush and reset: clr during OFFER with pending=8'h0C -> out_valid=0, pending=0 the next cycle.
//     Then rst_n low mid-stream -> all outputs at reset values asynchronously, and recovery after release.

Source files
------------

// File: rtl/event_encoder.sv
// ----------------------------------------------------------------------------
// event_encoder
//
// Purpose:
//   Sequential N-to-log2(N) encoder. Event requests on N lines are captured
//   into a sticky pending set. One pending source at a time is encoded into a
//   binary index and offered to a consumer over a valid/ready handshake. A
//   source's pending bit is cleared once its index has been taken. Selection
//   is either fixed priority (lowest index wins) or round-robin (rotating
//   after the last served index).
//
// Ports:
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   req_in       in   N      per-source event request, sampled every cycle
//   clr          in   1      synchronous flush of all pending events
//   out_valid    out  1      out_idx holds a valid encoded event
//   out_ready    in   1      consumer accepts out_idx when out_valid=1
//   out_idx      out  IDXW   encoded index of the event being offered
//   pending      out  N      registered pending set
//   any_pending  out  1      registered OR of the pending set
//   overflow     out  1      one-cycle pulse: request hit an already-pending bit
// ----------------------------------------------------------------------------
module event_encoder #(
    parameter int N           = 8,
    parameter int IDXW        = $clog2(N),
    parameter int ROUND_ROBIN = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic            clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    pending,
    output logic            any_pending,
    output logic            overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic            any_pending_q, any_pending_d;
    logic            overflow_q, overflow_d;

    logic            fire;
    logic [N-1:0]    served;
    logic [N-1:0]    avail;
    logic [IDXW-1:0] search_base;
    logic [IDXW-1:0] enc_idx;
    logic            enc_found;

    assign fire   = out_valid_q & out_ready;
    assign served = fire ? (N'(1) << out_idx_q) : '0;
    // The index being taken this cycle is excluded so the next offer can be
    // loaded back-to-back without repeating it.
    assign avail  = pending_q & ~served;

    // On a fire the pointer moves to the index just taken; using that value
    // immediately keeps the rotation correct for back-to-back offers.
    assign search_base = fire ? out_idx_q : rr_ptr_q;

    // Priority encoder over the available set.
    always_comb begin : encoder
        int cand;
        cand      = 0;
        enc_idx   = '0;
        enc_found = 1'b0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(search_base) + k) % N;
                if (!enc_found && avail[cand]) begin
                    enc_idx   = IDXW'(cand);
                    enc_found = 1'b1;
                end
            end
        end else begin
            // Scanning downward leaves the lowest set index as the winner.
            for (int i = N - 1; i >= 0; i--) begin
                if (avail[i]) begin
                    enc_idx   = IDXW'(i);
                    enc_found = 1'b1;
                end
            end
        end
    end

    // Next-state logic: pending set maintenance, offer FSM and flush.
    always_comb begin
        // A bit served and re-requested in the same cycle stays set as a new
        // event; it is not reported as an overflow because it was just taken.
        pending_d   = (pending_q & ~served) | req_in;
        overflow_d  = |(req_in & avail);
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;

        if (fire) begin
            rr_ptr_d = out_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (enc_found) begin
                    out_idx_d   = enc_idx;
                    out_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                // Without a fire the offer is held; later higher-priority
                // arrivals never preempt it.
                if (fire) begin
                    if (enc_found) begin
                        out_idx_d = enc_idx;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Flush drops everything including same-cycle requests; out_idx keeps
        // its last value so the output is never undefined.
        if (clr) begin
            pending_d   = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            state_d     = IDLE;
            rr_ptr_d    = IDXW'(N - 1);
        end

        any_pending_d = |pending_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            out_idx_q     <= '0;
            rr_ptr_q      <= IDXW'(N - 1);
            out_valid_q   <= 1'b0;
            any_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            out_idx_q     <= out_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            any_pending_q <= any_pending_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pending     = pending_q;
    assign any_pending = any_pending_q;
    assign overflow    = overflow_q;

endmodule
